serial_shifter: RTL
===================

// Module: serial_shifter
// PURPOSE
//   Multi-cycle shift execution unit: consumes the 5-bit shift amount produced by the
//   immediate limiter (or rs2[4:0]) and shifts op_a by STEP bits per clock.
//   Sits in the execute stage beside the ALU as a low-area SLL/SRL/SRA engine;
//   the core stalls on busy and picks up result on done.
// PARAMETERS
//   XLEN     32  operand/result width
//   SHAMT_W  5   shift-amount width (log2 XLEN)
//   STEP     1   max bits shifted per cycle; legal 1..XLEN/2, power of two
// PORTS
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request; accepted when busy==0
//   kill     in   1        synchronous abort (pipeline flush)
//   op_sel   in   2        00 SLL, 01 SRL, 11 SRA, 10 reserved (executes as SLL)
//   op_a     in   XLEN     value to shift, sampled on accepted start
//   shamt    in   SHAMT_W  shift amount, sampled on accepted start
//   busy     out  1        high while in SHIFT
//   done     out  1        one-cycle completion pulse
//   result   out  XLEN     last completed result
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, internal acc/rem=0.
//   FSM states: IDLE, SHIFT, DONE.
//   - IDLE/DONE: start=1 & kill=0 -> latch acc=op_a, rem=shamt, op=op_sel;
//       rem==0 -> DONE, else -> SHIFT. start=0 -> IDLE.
//   - SHIFT: each edge: k=min(rem,STEP); acc shifted by k; rem-=k;
//       new rem==0 -> DONE and result<=shifted acc; else stay SHIFT. start ignored.
//   - DONE lasts exactly one cycle (done=1); result written on entry to DONE.
//   - shamt==0: result<=op_a on entry to DONE.
//   Latency: start accepted in cycle T -> done=1 in cycle T+1+ceil(shamt/STEP).
//   Back-to-back: start during DONE cycle accepted; no idle bubble required.
//   Shift rules: SLL fills zeros at LSB; SRL fills zeros at MSB; SRA replicates
//     acc[XLEN-1] (sign captured from op_a). Never shift by more than rem.
//   rem width SHAMT_W; no wrap (decrement saturates at 0 by construction).
//   result stable between done pulses; changes only on entry to DONE.
//   kill=1: next edge -> IDLE from any state, busy=0, no done pulse, result unchanged;
//     kill has priority over start in the same cycle.
//   Reset mid-operation: immediate return to reset values; no done afterwards.
//   op_a/shamt/op_sel changes while busy have no effect.
// TESTING
//   STEP=1, SLL 0x0000_0001 shamt=31 start@T -> busy T+1..T+31, done@T+32, result 0x8000_0000.
//   SRA 0x8000_0000 shamt=4 -> result 0xF800_0000; SRL same -> 0x0800_0000; op_sel=10 -> 0x0000_0000.
//   shamt=0, op_a=0xDEAD_BEEF start@T -> busy never high, done@T+1, result 0xDEAD_BEEF.
//   STEP=4, SLL 0x0000_0003 shamt=5 -> two SHIFT cycles, done@T+3, result 0x0000_0060.
//   start asserted in DONE cycle with SRL 0xFFFF_FFFF shamt=8 -> accepted, next done gives 0x00FF_FFFF.
//   kill at T+3 of shamt=20 -> IDLE at T+4, no done, result keeps prior value; rst_n low mid-op -> all outputs 0.

Source files
------------

// File: rtl/serial_shifter_if.sv
// Request/response bundle between the execute stage and the serial shift unit.
interface serial_shifter_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) ();

  logic               start;
  logic               kill;
  logic [1:0]         op_sel;
  logic [XLEN-1:0]    op_a;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [XLEN-1:0]    result;

  // Core side: issues requests, watches busy/done.
  modport master (
    output start, kill, op_sel, op_a, shamt,
    input  busy, done, result
  );

  // Shift unit side.
  modport slave (
    input  start, kill, op_sel, op_a, shamt,
    output busy, done, result
  );

endinterface

// File: rtl/serial_shifter.sv
// Multi-cycle SLL/SRL/SRA engine: shifts the latched operand by up to STEP bits per clock,
// signals busy while shifting and pulses done for one cycle when the result is written.
module serial_shifter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_shifter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);

  state_e             state_q;
  logic [XLEN-1:0]    acc_q;
  logic [XLEN-1:0]    result_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [1:0]         op_q;

  logic [SHAMT_W-1:0] step_k;
  logic [SHAMT_W-1:0] rem_next;
  logic [XLEN-1:0]    acc_shifted;

  // One shift step: never move by more than the bits still owed.
  always_comb begin
    step_k      = (rem_q < StepAmt) ? rem_q : StepAmt;
    rem_next    = rem_q - step_k;
    acc_shifted = acc_q << step_k;
    case (op_q)
      2'b01:   acc_shifted = acc_q >> step_k;
      2'b11:   acc_shifted = $unsigned($signed(acc_q) >>> step_k);
      default: acc_shifted = acc_q << step_k;  // SLL, and reserved 2'b10 behaves as SLL
    endcase
  end

  // Control FSM with operand/remaining-count and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else if (bus.kill) begin
      // Flush wins over everything, including a same-cycle start; result is preserved.
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            acc_q <= bus.op_a;
            rem_q <= bus.shamt;
            op_q  <= bus.op_sel;
            if (bus.shamt == '0) begin
              result_q <= bus.op_a;
              state_q  <= StDone;
            end else begin
              state_q <= StShift;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          acc_q <= acc_shifted;
          rem_q <= rem_next;
          if (rem_next == '0) begin
            result_q <= acc_shifted;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = (state_q == StShift);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule
